// File: rtl/fpu_div_pack_if.sv
// Divider-to-writeback handshake bundle for the quotient packer.
// The master drives raw quotients and write-port ready; the slave packs.
interface fpu_div_pack_if;
  logic        div_valid;
  logic [31:0] div_mantissa;
  logic [7:0]  div_exponent;
  logic        div_sign;
  logic [4:0]  div_dest;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        pack_busy;
  logic        err_overrun;

  modport master (
    output div_valid,
    output div_mantissa,
    output div_exponent,
    output div_sign,
    output div_dest,
    output wb_ready,
    input  wb_valid,
    input  wb_dest,
    input  wb_data,
    input  pack_busy,
    input  err_overrun
  );

  modport slave (
    input  div_valid,
    input  div_mantissa,
    input  div_exponent,
    input  div_sign,
    input  div_dest,
    input  wb_ready,
    output wb_valid,
    output wb_dest,
    output wb_data,
    output pack_busy,
    output err_overrun
  );
endinterface

// File: rtl/fpu_div_pack.sv
// Normalizes, rounds (RNE) and packs a raw divider quotient into an
// IEEE-754 single, then offers it to the register-file write port.
module fpu_div_pack (
  input  logic           clock,
  input  logic           reset,
  fpu_div_pack_if.slave  io
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] WB    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] mant_q, mant_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [4:0]  dest_q, dest_d;
  logic [22:0] frac_q, frac_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [9:0]  nexp_q, nexp_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic        err_q, err_d;

  logic        xfer;
  logic        accept;
  logic        inc;
  logic [23:0] frac_sum;
  logic [9:0]  exp_r;

  assign xfer   = (state_q == WB) && io.wb_ready;
  assign accept = io.div_valid && ((state_q == IDLE) || xfer);

  always_comb begin
    state_d   = state_q;
    mant_d    = mant_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    dest_d    = dest_q;
    frac_d    = frac_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    nexp_d    = nexp_q;
    wb_data_d = wb_data_q;
    wb_dest_d = wb_dest_q;
    err_d     = err_q;
    inc       = guard_q & (sticky_q | frac_q[0]);
    frac_sum  = {1'b0, frac_q} + {23'd0, inc};
    exp_r     = nexp_q + {9'd0, frac_sum[23]};

    if (accept) begin
      mant_d = io.div_mantissa;
      exp_d  = io.div_exponent;
      sign_d = io.div_sign;
      dest_d = io.div_dest;
    end
    if (io.div_valid && !accept) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (io.div_valid) state_d = NORM;
      end
      NORM: begin
        if (mant_q[30]) begin
          frac_d   = mant_q[29:7];
          guard_d  = mant_q[6];
          sticky_d = |mant_q[5:0];
        end else begin
          frac_d   = mant_q[28:6];
          guard_d  = mant_q[5];
          sticky_d = |mant_q[4:0];
        end
        nexp_d  = {2'b00, exp_q} - {9'd0, ~mant_q[30]};
        state_d = ROUND;
      end
      ROUND: begin
        wb_dest_d = dest_q;
        // exp_r is two's complement; bit 9 flags an underflowed exponent
        if (mant_q == 32'd0) begin
          wb_data_d = {sign_q, 31'd0};
        end else if (exp_q == 8'hFF) begin
          wb_data_d = {sign_q, 8'hFF, 23'd0};
        end else if (exp_r[9] || exp_r == 10'd0) begin
          wb_data_d = {sign_q, 31'd0};
        end else if (exp_r >= 10'd255) begin
          wb_data_d = {sign_q, 8'hFF, 23'd0};
        end else begin
          wb_data_d = {sign_q, exp_r[7:0], frac_sum[22:0]};
        end
        state_d = WB;
      end
      WB: begin
        if (xfer) state_d = io.div_valid ? NORM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      mant_q    <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      dest_q    <= '0;
      frac_q    <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      nexp_q    <= '0;
      wb_data_q <= '0;
      wb_dest_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mant_q    <= mant_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      dest_q    <= dest_d;
      frac_q    <= frac_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      nexp_q    <= nexp_d;
      wb_data_q <= wb_data_d;
      wb_dest_q <= wb_dest_d;
      err_q     <= err_d;
    end
  end

  assign io.wb_valid    = (state_q == WB);
  assign io.wb_data     = wb_data_q;
  assign io.wb_dest     = wb_dest_q;
  assign io.pack_busy   = (state_q != IDLE);
  assign io.err_overrun = err_q;

endmodule

// File: doc/fpu_div_pack.md
FPU_DIV_PACK -- requirements
Module: fpu_div_pack

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 div_valid  in  1  one-cycle pulse; raw quotient fields valid this cycle.
REQ-005 div_mantissa  in  32  raw quotient; value = div_mantissa * 2^-30; bit 31 always 0.
REQ-006 div_exponent  in  8  biased exponent before normalization, unsigned.
REQ-007 div_sign  in  1  result sign.
REQ-008 div_dest  in  5  destination register index.
REQ-009 wb_valid  out  1  packed result offered to the register-file write port.
REQ-010 wb_ready  in  1  write port accepts; a transfer occurs when wb_valid and wb_ready are both high.
REQ-011 wb_dest  out  5  destination register of the offered result.
REQ-012 wb_data  out  32  IEEE-754 single-precision result.
REQ-013 pack_busy  out  1  high whenever state is not IDLE; gates the divider start.
REQ-014 err_overrun  out  1  sticky; a div_valid arrived and was dropped.

Function
REQ-015 FSM states SHALL be IDLE, NORM, ROUND and WB.
REQ-016 IDLE with div_valid: capture all div_* fields and go to NORM; otherwise stay in IDLE.
REQ-017 NORM: normalize and register the result, then go to ROUND unconditionally.
  - bit 30 set: frac = bits[29:7], guard = bit 6, sticky = OR(bits[5:0]), exp unchanged.
  - else: frac = bits[28:6], guard = bit 5, sticky = OR(bits[4:0]), exp = exp - 1 (9-bit signed).
REQ-018 ROUND: apply round-to-nearest-even, pack the result into wb_data/wb_dest, then go to WB.
  - Round-to-nearest-even: increment frac if guard and (sticky or frac[0]).
  - Carry out of frac: frac = 0, exp + 1.
REQ-019 Special cases SHALL be applied in priority order:
  - div_mantissa == 0: signed zero {sign, 31'b0}.
  - Captured div_exponent == 255: signed infinity {sign, 8'hFF, 23'b0}.
  - Final exp <= 0: flush to signed zero; no denormal output.
  - Final exp >= 255: signed infinity.
  - Otherwise: {sign, exp[7:0], frac}.
REQ-020 WB: wb_valid SHALL be 1, with wb_data and wb_dest held stable until the transfer occurs.
REQ-021 On a WB transfer: go to IDLE, deasserting wb_valid on the next cycle.
REQ-022 WB transfer with div_valid in the same cycle: the new operand SHALL be captured and the state SHALL go to NORM (back-to-back).
REQ-023 div_valid in NORM, in ROUND, or in WB without a transfer: input dropped, err_overrun set to 1, in-flight result unaffected.
REQ-024 Latency: div_valid in cycle n gives wb_valid high from cycle n+3, with an ideal write port.
REQ-025 pack_busy SHALL be combinational from state only, with no dependence on wb_ready.
REQ-026 err_overrun SHALL be cleared only by reset.

Reset
REQ-027 While reset is high, state SHALL become IDLE and every output SHALL go to 0 on the next edge: wb_valid, wb_data, wb_dest, pack_busy, err_overrun.
REQ-028 Reset SHALL take priority over div_valid and wb_ready in the same cycle.
REQ-029 Reset mid-operation SHALL discard the in-flight result; no wb_valid is issued for it.

Verification
REQ-030 Exact quotient (6.0/2.0): div_mantissa=0x60000000, exp=128, sign=0, dest=3, wb_ready=1 -> wb_valid at n+3, wb_data=0x40400000, wb_dest=3.
REQ-031 Normalize plus round up (1.0/3.0): div_mantissa=0x2AAAAAAA, exp=126 -> wb_data=0x3EAAAAAB.
REQ-032 Round carry: div_mantissa=0x7FFFFFFF, exp=127, sign=1 -> wb_data=0xC0000000.
REQ-033 Limits, each checked separately:
  - div_mantissa=0, sign=1 -> 0x80000000.
  - div_mantissa=0x20000000, exp=1 -> 0x00000000 (flush).
  - div_mantissa=0x7FFFFFFF, exp=254 -> 0x7F800000.
REQ-034 Back-pressure: wb_ready held low 5 cycles with div_valid pulsed in WB -> wb_valid/wb_data stable, err_overrun=1, single transfer on wb_ready.
REQ-035 Back-to-back and reset:
  - div_valid in the same cycle as a WB transfer -> second result emitted 3 cycles later.
  - reset asserted in ROUND -> wb_valid never rises, all outputs 0.
